// File: rtl/sync_fifo_flex_pkg.sv
// Shared constants and helpers for the flexible synchronous FIFO.
package sync_fifo_pkg;

   localparam int FIFO_MODE_STD  = 0;
   localparam int FIFO_MODE_FWFT = 1;

   // Advance a pointer with an explicit wrap at depth-1, so any depth works.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
   endfunction

   // Bits needed to hold a fill level of 0..depth inclusive.
   function automatic int clog2_lvl(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_flex.
interface sync_fifo_flex_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
);
   localparam int LVL = sync_fifo_pkg::clog2_lvl(DEPTH);

   logic             wr;
   logic [WIDTH-1:0] Wdata;
   logic             rd;
   logic             clr_err;
   logic [WIDTH-1:0] Rdata;
   logic             Rvalid;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [LVL-1:0]   level;
   logic             overflow;
   logic             underflow;

   modport master (
      output wr, Wdata, rd, clr_err,
      input  Rdata, Rvalid, full, empty, almost_full, almost_empty, level, overflow, underflow
   );

   modport slave (
      input  wr, Wdata, rd, clr_err,
      output Rdata, Rvalid, full, empty, almost_full, almost_empty, level, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_flex_regfile.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_regfile #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int ADDR  = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ADDR-1:0]  waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [ADDR-1:0]  raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

   // Next-state of the array: only the addressed word changes on a write.
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   // Storage flops; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, standard/FWFT read, level and sticky error flags.
module sync_fifo_flex
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int FWFT      = FIFO_MODE_STD,
   parameter int AF_THRESH = 6,
   parameter int AE_THRESH = 2
) (
   input logic             clk,
   input logic             reset,
   sync_fifo_flex_if.slave bus
);
   localparam int ADDR = $clog2(DEPTH);
   localparam int LVL  = clog2_lvl(DEPTH);
   localparam logic [LVL-1:0] LVL_FULL = LVL'(DEPTH);
   localparam logic [LVL-1:0] LVL_AF   = LVL'(AF_THRESH);
   localparam logic [LVL-1:0] LVL_AE   = LVL'(AE_THRESH);

   logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL-1:0]   level_q, level_d;
   logic             overflow_q, overflow_d, underflow_q, underflow_d;
   logic             empty, full, rd_acc, wr_acc;
   logic [WIDTH-1:0] mem_rdata;

   // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
   assign empty  = (level_q == '0);
   assign full   = (level_q == LVL_FULL);
   assign rd_acc = bus.rd & ~empty;
   assign wr_acc = bus.wr & (~full | rd_acc);

   fifo_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) u_regfile (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q),
      .wdata (bus.Wdata),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   // Pointer, level and sticky-error next state; a new error beats a clear in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_acc) wr_ptr_d = ADDR'(ptr_inc(32'(wr_ptr_q), DEPTH));
      if (rd_acc) rd_ptr_d = ADDR'(ptr_inc(32'(rd_ptr_q), DEPTH));
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + LVL'(1);
         2'b01:   level_d = level_q - LVL'(1);
         default: level_d = level_q;
      endcase
      overflow_d  = (overflow_q  & ~bus.clr_err) | (bus.wr & ~wr_acc);
      underflow_d = (underflow_q & ~bus.clr_err) | (bus.rd & empty);
   end

   // Control state flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is presented directly from storage; Rdata is meaningless while empty.
      assign bus.Rdata  = mem_rdata;
      assign bus.Rvalid = ~empty;
   end else begin : g_std
      logic [WIDTH-1:0] rdata_q, rdata_d;
      logic             rvalid_q, rvalid_d;

      // Capture the head on a pop and hold it otherwise; valid pulses for one cycle.
      always_comb begin
         rdata_d  = rd_acc ? mem_rdata : rdata_q;
         rvalid_d = rd_acc;
      end

      // Registered read port.
      always_ff @(posedge clk) begin
         if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
         end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
         end
      end

      assign bus.Rdata  = rdata_q;
      assign bus.Rvalid = rvalid_q;
   end

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (level_q >= LVL_AF);
   assign bus.almost_empty = (level_q <= LVL_AE);
   assign bus.level        = level_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule
